// File: rtl/fabric_frame_config_sequencer_if.sv
// Bitstream word stream into the configuration sequencer: a 32-bit word
// transferred on any cycle where s_valid and s_ready are both high.
interface fabric_frame_config_sequencer_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/fabric_frame_config_sequencer.sv
// Fabric frame configuration sequencer: waits for a sync word, decodes a
// frame-address header, gathers one word per row into FrameData, then pulses
// the single FrameStrobe line of the addressed column/frame.
module fabric_frame_config_sequencer #(
    parameter int          NumColumns      = 4,
    parameter int          NumRows         = 4,
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
    parameter logic [31:0] DesyncWord      = 32'hFAB0_FAB0
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    fabric_frame_config_sequencer_if.slave        s_if,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  cfg_done,
    output logic                                  addr_err
);

    localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int ColW    = (NumColumns > 1) ? $clog2(NumColumns) : 1;
    localparam int StrobeW = NumColumns * MaxFramesPerCol;
    localparam int DataW   = NumRows * FrameBitsPerRow;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_STROBE,
        ST_SKIP
    } state_t;

    state_t              state_q, state_d;
    logic [RowW-1:0]     row_q, row_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [4:0]          frame_q, frame_d;
    logic [DataW-1:0]    frame_data_q, frame_data_d;
    logic [StrobeW-1:0]  frame_strobe_q, frame_strobe_d;
    logic                busy_q, busy_d;
    logic                cfg_done_q, cfg_done_d;
    logic                addr_err_q, addr_err_d;

    logic                accept;
    logic [7:0]          hdr_col;
    logic [4:0]          hdr_frame;
    logic                hdr_legal;
    logic                last_row;
    int                  strobe_idx;

    // The sequencer stalls the stream only during the single strobe cycle.
    assign s_if.s_ready = (state_q != ST_STROBE);
    assign accept       = s_if.s_valid && s_if.s_ready;
    assign hdr_col      = s_if.s_data[15:8];
    assign hdr_frame    = s_if.s_data[4:0];
    assign hdr_legal    = (int'(hdr_col) < NumColumns) && (int'(hdr_frame) < MaxFramesPerCol);
    assign last_row     = (row_q == RowW'(NumRows - 1));
    assign strobe_idx   = int'(col_q) * MaxFramesPerCol + int'(frame_q);

    // Next-state, counter, frame assembly and registered-output decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        frame_d        = frame_q;
        frame_data_d   = frame_data_q;
        frame_strobe_d = '0;
        cfg_done_d     = 1'b0;
        addr_err_d     = addr_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept && s_if.s_data == SyncWord) begin
                    state_d    = ST_HEADER;
                    addr_err_d = 1'b0;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    if (s_if.s_data == DesyncWord) begin
                        state_d    = ST_IDLE;
                        cfg_done_d = 1'b1;
                    end else if (s_if.s_data == SyncWord) begin
                        state_d = ST_HEADER;
                    end else if (hdr_legal) begin
                        state_d = ST_DATA;
                        row_d   = '0;
                        col_d   = hdr_col[ColW-1:0];
                        frame_d = hdr_frame;
                    end else begin
                        state_d    = ST_SKIP;
                        row_d      = '0;
                        addr_err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    for (int r = 0; r < NumRows; r++) begin
                        if (row_q == RowW'(r)) begin
                            frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = s_if.s_data;
                        end
                    end
                    if (last_row) begin
                        state_d        = ST_STROBE;
                        frame_strobe_d = StrobeW'(1) << strobe_idx;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            ST_STROBE: begin
                state_d = ST_HEADER;
            end
            ST_SKIP: begin
                if (accept) begin
                    if (last_row) begin
                        state_d = ST_HEADER;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any partially built frame.
    always_ff @(posedge CLK or negedge resetn) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (!resetn) begin
            state_q        <= ST_IDLE;
            row_q          <= '0;
            col_q          <= '0;
            frame_q        <= '0;
            frame_data_q   <= '0;
            frame_strobe_q <= '0;
            busy_q         <= 1'b0;
            cfg_done_q     <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            frame_q        <= frame_d;
            frame_data_q   <= frame_data_d;
            frame_strobe_q <= frame_strobe_d;
            busy_q         <= busy_d;
            cfg_done_q     <= cfg_done_d;
            addr_err_q     <= addr_err_d;
        end
    end

    assign FrameData   = frame_data_q;
    assign FrameStrobe = frame_strobe_q;
    assign busy        = busy_q;
    assign cfg_done    = cfg_done_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_fabric_frame_config_sequencer.sv
// Scoreboard bench: the driver feeds words into a frame-level reference model
// that queues expected strobe / cfg_done events; a monitor pops and compares
// each event when the sequencer presents it.
module tb_fabric_frame_config_sequencer;

    localparam int          NC     = 4;
    localparam int          NR     = 4;
    localparam int          MF     = 20;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic              CLK = 1'b0;
    logic              resetn = 1'b0;
    logic [NR*32-1:0]  FrameData;
    logic [NC*MF-1:0]  FrameStrobe;
    logic              busy, cfg_done, addr_err;

    fabric_frame_config_sequencer_if s_if ();

    fabric_frame_config_sequencer #(
        .NumColumns(NC), .NumRows(NR), .MaxFramesPerCol(MF), .FrameBitsPerRow(32),
        .SyncWord(SYNC), .DesyncWord(DESYNC)
    ) dut (
        .CLK(CLK), .resetn(resetn), .s_if(s_if),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .busy(busy), .cfg_done(cfg_done), .addr_err(addr_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Expected observable events produced by the reference model.
    typedef struct {
        bit               is_cfg;
        int               edge_n;
        int               idx;
        logic [NR*32-1:0] fd;
        bit               err;
    } ev_t;
    ev_t exp_q[$];

    // Reference model: configuration mode, collected frame words, row images.
    typedef enum { M_IDLE, M_HEADER, M_DATA, M_SKIP } mode_t;
    mode_t       m_mode = M_IDLE;
    bit          m_err = 0;
    int          m_idx = 0;
    logic [31:0] m_words[$];
    logic [31:0] m_rows[NR];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR*32-1:0] model_fd();
        logic [NR*32-1:0] p;
        for (int r = 0; r < NR; r++) p[r*32 +: 32] = m_rows[r];
        return p;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_err  = 0;
        m_words.delete();
        for (int r = 0; r < NR; r++) m_rows[r] = '0;
        exp_q.delete();
    endtask

    // Applies one accepted word; edge_n is the clock edge that accepts it.
    task automatic model_accept(input logic [31:0] w, input int edge_n);
        ev_t ev;
        case (m_mode)
            M_IDLE: if (w == SYNC) begin m_mode = M_HEADER; m_err = 0; end
            M_HEADER: begin
                if (w == DESYNC) begin
                    m_mode = M_IDLE;
                    ev = '{is_cfg: 1, edge_n: edge_n, idx: 0, fd: model_fd(), err: m_err};
                    exp_q.push_back(ev);
                end else if (w != SYNC) begin
                    m_words.delete();
                    if (int'(w[15:8]) < NC && int'(w[4:0]) < MF) begin
                        m_idx  = int'(w[15:8]) * MF + int'(w[4:0]);
                        m_mode = M_DATA;
                    end else begin
                        m_err  = 1;
                        m_mode = M_SKIP;
                    end
                end
            end
            M_DATA: begin
                m_words.push_back(w);
                if (m_words.size() == NR) begin
                    for (int r = 0; r < NR; r++) m_rows[r] = m_words[r];
                    ev = '{is_cfg: 0, edge_n: edge_n, idx: m_idx, fd: model_fd(), err: m_err};
                    exp_q.push_back(ev);
                    m_mode = M_HEADER;
                end
            end
            M_SKIP: begin
                m_words.push_back(w);
                if (m_words.size() == NR) m_mode = M_HEADER;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // Presents one word after `gap` idle cycles and waits (bounded) for acceptance.
    task automatic send_word(input logic [31:0] w, input int gap);
        int k;
        s_if.s_valid = 1'b0;
        repeat (gap) @(negedge CLK);
        s_if.s_data  = w;
        s_if.s_valid = 1'b1;
        for (k = 0; k < 16 && !s_if.s_ready; k++) @(negedge CLK);
        if (!s_if.s_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: s_ready stayed 0 for word %0h", w);
        end else begin
            model_accept(w, cyc + 1);
            @(negedge CLK);
        end
        s_if.s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input int max_gap);
        send_word(hdr, $urandom_range(max_gap));
        for (int r = 0; r < NR; r++) send_word($urandom, $urandom_range(max_gap));
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"}, busy, (m_mode != M_IDLE));
        check({tag, "_addr_err"}, addr_err, m_err);
    endtask

    // Monitor: every strobe or cfg_done cycle must match the next queued event.
    always @(negedge CLK) begin
        if (resetn && (FrameStrobe != '0 || cfg_done)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: strobe %0h cfg_done %0b expected none", FrameStrobe, cfg_done);
            end else begin
                ev_t              ev;
                logic [NC*MF-1:0] exp_strobe;
                ev = exp_q.pop_front();
                exp_strobe = ev.is_cfg ? '0 : ((NC*MF)'(1) << ev.idx);
                check("event_cycle", cyc, ev.edge_n);
                check("cfg_done", cfg_done, ev.is_cfg);
                check("frame_strobe", FrameStrobe, exp_strobe);
                check("addr_err_at_event", addr_err, ev.err);
                if (!ev.is_cfg) begin
                    check("frame_data", FrameData, ev.fd);
                    check("s_ready_in_strobe", s_if.s_ready, 1'b0);
                end
            end
        end
    end

    // Watchdog so the run ends even if the stimulus process stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a[NR];
        s_if.s_data  = '0;
        s_if.s_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        check("rst_frame_data", FrameData, '0);
        check("rst_strobe", FrameStrobe, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_s_ready", s_if.s_ready, 1'b1);
        resetn = 1'b1;
        @(negedge CLK);

        // Words before sync are discarded.
        send_word(32'h1234_5678, 0);
        send_word(DESYNC, 1);
        check_status("pre_sync");

        // Basic frame to column 2, frame 3.
        send_word(SYNC, 0);
        send_word(32'h0000_0203, 0);
        for (int r = 0; r < NR; r++) begin
            a[r] = 32'hA000_0000 + r;
            send_word(a[r], 0);
        end
        repeat (2) @(negedge CLK);
        check("basic_frame_data", FrameData, {a[3], a[2], a[1], a[0]});
        check_status("basic");

        // Illegal column skips its data, then a legal frame still strobes.
        send_frame(32'h0000_0400, 0);
        check_status("skip");
        check("skip_frame_data", FrameData, model_fd());
        send_frame(32'h0000_0000, 0);
        repeat (2) @(negedge CLK);
        check_status("after_skip");

        // Highest column/frame with random stalls.
        send_frame(32'h0000_0313, 5);
        repeat (2) @(negedge CLK);

        // Desync as data, then desync as header ends configuration.
        send_word(32'h0000_0105, 0);
        send_word(32'h1111_1111, 0);
        send_word(DESYNC, 2);
        send_word(SYNC, 0);
        send_word(32'h2222_2222, 1);
        send_word(DESYNC, 3);
        repeat (2) @(negedge CLK);
        check_status("desync");
        send_word(32'h0000_0101, 0);
        check_status("idle_header");

        // Reset in the middle of a frame clears partial data, no strobe.
        send_word(SYNC, 0);
        send_word(32'h0000_0101, 0);
        send_word(32'hBEEF_0000, 0);
        send_word(32'hBEEF_0001, 0);
        #2 resetn = 1'b0;
        model_reset();
        @(negedge CLK);
        check("midrst_frame_data", FrameData, '0);
        check("midrst_strobe", FrameStrobe, '0);
        resetn = 1'b1;
        send_frame(32'h0000_0203, 0);
        repeat (2) @(negedge CLK);
        check_status("post_reset");
        check("post_reset_frame_data", FrameData, '0);

        // Randomised traffic, including illegal addresses and re-sync.
        send_word(SYNC, 0);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(9) == 0) begin
                send_word(DESYNC, $urandom_range(3));
                send_word(SYNC, $urandom_range(3));
            end else begin
                logic [31:0] hdr;
                hdr        = $urandom;
                hdr[15:8]  = 8'($urandom_range(5));
                hdr[4:0]   = 5'($urandom_range(24));
                send_frame(hdr, 3);
            end
        end
        repeat (4) @(negedge CLK);
        check_status("random_end");
        check("events_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
